// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache way controller.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_RESPOND
  } cache_state_e;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int way_w(input int num_ways);
    return $clog2(num_ways);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_sets, input int line_bytes);
    return addr_w - idx_w(num_sets) - off_w(line_bytes);
  endfunction

  // {tag, idx, zero offset}; callers truncate to their address width
  function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] idx,
                                            input int idx_bits, input int off_bits);
    return ((tag << idx_bits) | idx) << off_bits;
  endfunction

endpackage

// File: rtl/cache_tag_match.sv
// Combinational tag compare across the ways of one set, with lowest-way priority.
module cache_tag_match #(
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 24,
  parameter int WAY_W    = 2
) (
  input  logic [NUM_WAYS-1:0][TAG_W-1:0] tags,
  input  logic [NUM_WAYS-1:0]            valids,
  input  logic [TAG_W-1:0]               lookup_tag,
  output logic                           hit,
  output logic [WAY_W-1:0]               hit_way,
  output logic                           has_invalid,
  output logic [WAY_W-1:0]               first_invalid_way,
  output logic                           multi_hit
);

  logic [NUM_WAYS-1:0] match;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign match[w] = valids[w] && (tags[w] == lookup_tag);
  end

  // Scan high to low so the lowest matching / invalid way wins.
  always_comb begin
    hit_way           = '0;
    first_invalid_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w])   hit_way           = WAY_W'(w);
      if (!valids[w]) first_invalid_way = WAY_W'(w);
    end
  end

  assign hit         = |match;
  assign has_invalid = ~&valids;
  assign multi_hit   = (match & (match - NUM_WAYS'(1))) != '0;

endmodule

// File: rtl/cache_way_ctrl.sv
// Tag/state controller: lookup, victim choice, dirty writeback and line fill sequencing.
import cache_pkg::*;

module cache_way_ctrl #(
  parameter  int NUM_WAYS   = 4,
  parameter  int NUM_SETS   = 16,
  parameter  int ADDR_W     = 32,
  parameter  int LINE_BYTES = 16,
  localparam int OFF_W      = off_w(LINE_BYTES),
  localparam int IDX_W      = idx_w(NUM_SETS),
  localparam int TAG_W      = tag_w(ADDR_W, NUM_SETS, LINE_BYTES),
  localparam int WAY_W      = way_w(NUM_WAYS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [IDX_W-1:0]  resp_set,
  output logic [WAY_W-1:0]  resp_way,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_write,
  input  logic              mem_resp_valid,
  output logic [IDX_W-1:0]  plru_set,
  input  logic [WAY_W-1:0]  plru_lru_way,
  output logic [WAY_W-1:0]  plru_mru_way,
  output logic              plru_load_mru
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0] tag_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            dirty_q;

  cache_state_e     state;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic             r_write;
  logic             r_hit;
  logic [WAY_W-1:0] r_way;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_invalid;
  logic [WAY_W-1:0] first_invalid_way;
  logic             multi_hit;
  logic [WAY_W-1:0] victim;
  logic             unused_offset;

  assign unused_offset = ^req_addr[OFF_W-1:0];
  assign plru_set      = r_idx;

  cache_tag_match #(
    .NUM_WAYS (NUM_WAYS),
    .TAG_W    (TAG_W),
    .WAY_W    (WAY_W)
  ) u_match (
    .tags              (tag_q[r_idx]),
    .valids            (valid_q[r_idx]),
    .lookup_tag        (r_tag),
    .hit               (hit),
    .hit_way           (hit_way),
    .has_invalid       (has_invalid),
    .first_invalid_way (first_invalid_way),
    .multi_hit         (multi_hit)
  );

  // Free ways are consumed before the PLRU choice is honoured.
  assign victim = has_invalid ? first_invalid_way : plru_lru_way;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      tag_q         <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      r_tag         <= '0;
      r_idx         <= '0;
      r_write       <= 1'b0;
      r_hit         <= 1'b0;
      r_way         <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_set      <= '0;
      resp_way      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_write <= 1'b0;
      plru_mru_way  <= '0;
      plru_load_mru <= 1'b0;
    end else begin
      resp_valid    <= 1'b0;
      plru_load_mru <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_tag     <= req_addr[ADDR_W-1:IDX_W+OFF_W];
            r_idx     <= req_addr[IDX_W+OFF_W-1:OFF_W];
            r_write   <= req_write;
            req_ready <= 1'b0;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            r_hit         <= 1'b1;
            r_way         <= hit_way;
            if (r_write) dirty_q[r_idx][hit_way] <= 1'b1;
            resp_valid    <= 1'b1;
            resp_hit      <= 1'b1;
            resp_set      <= r_idx;
            resp_way      <= hit_way;
            plru_load_mru <= 1'b1;
            plru_mru_way  <= hit_way;
            state         <= S_RESPOND;
          end else begin
            r_hit         <= 1'b0;
            r_way         <= victim;
            mem_req_valid <= 1'b1;
            if (valid_q[r_idx][victim] && dirty_q[r_idx][victim]) begin
              mem_req_write <= 1'b1;
              mem_req_addr  <= ADDR_W'(line_addr(64'(tag_q[r_idx][victim]), 64'(r_idx),
                                                 IDX_W, OFF_W));
              state         <= S_WB_REQ;
            end else begin
              mem_req_write <= 1'b0;
              mem_req_addr  <= ADDR_W'(line_addr(64'(r_tag), 64'(r_idx), IDX_W, OFF_W));
              state         <= S_FILL_REQ;
            end
          end
        end
        S_WB_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WB_WAIT;
          end
        end
        S_WB_WAIT: begin
          if (mem_resp_valid) begin
            dirty_q[r_idx][r_way] <= 1'b0;
            mem_req_valid         <= 1'b1;
            mem_req_write         <= 1'b0;
            mem_req_addr          <= ADDR_W'(line_addr(64'(r_tag), 64'(r_idx), IDX_W, OFF_W));
            state                 <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            tag_q[r_idx][r_way]   <= r_tag;
            valid_q[r_idx][r_way] <= 1'b1;
            dirty_q[r_idx][r_way] <= r_write;
            resp_valid            <= 1'b1;
            resp_hit              <= r_hit;
            resp_set              <= r_idx;
            resp_way              <= r_way;
            plru_load_mru         <= 1'b1;
            plru_mru_way          <= r_way;
            state                 <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // A line can only be filled after missing, so two matching ways means corrupted state.
  always_ff @(posedge clk) begin
    if (!reset && state == S_LOOKUP) assert (!multi_hit);
  end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Scoreboard bench: stimulus pushes model expectations, monitors pop on DUT outputs.
module tb_cache_way_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
  } exp_mem_t;

  typedef struct {
    logic       hit;
    logic [3:0] set;
    logic [1:0] way;
    int         acc;
  } exp_resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        resp_valid, resp_hit;
  logic [3:0]  resp_set;
  logic [1:0]  resp_way;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_write;
  logic        mem_resp_valid = 1'b0;
  logic [3:0]  plru_set;
  logic [1:0]  plru_lru_way = '0;
  logic [1:0]  plru_mru_way;
  logic        plru_load_mru;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_count = 0;

  exp_mem_t  exp_mem[$];
  exp_resp_t exp_resp[$];

  // reference cache contents
  logic [23:0] m_tag[16][4];
  bit          m_val[16][4];
  bit          m_dirty[16][4];

  // memory-side knobs
  int lat_cfg = 3;
  int stall_cfg = 0;
  bit rand_mode = 0;
  bit glitch = 0;

  cache_way_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_write      (req_write),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_set       (resp_set),
    .resp_way       (resp_way),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_write  (mem_req_write),
    .mem_resp_valid (mem_resp_valid),
    .plru_set       (plru_set),
    .plru_lru_way   (plru_lru_way),
    .plru_mru_way   (plru_mru_way),
    .plru_load_mru  (plru_load_mru)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 60000", cyc);
    $fatal(1);
  end

  task automatic finish_up();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_val[s][w]   = 0;
        m_dirty[s][w] = 0;
        m_tag[s][w]   = '0;
      end
  endtask

  // Memory responder plus request-port monitor.
  bit          busy = 0;
  int          lat_left = 0;
  int          stall_left = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;
  logic        prev_wr = 1'b0;

  always @(negedge clk) begin
    logic rdy;
    exp_mem_t e;
    mem_resp_valid = 1'b0;
    if (busy) begin
      lat_left--;
      if (lat_left <= 0) begin
        mem_resp_valid = 1'b1;
        busy = 0;
      end
    end
    if (prev_wait) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr || mem_req_write !== prev_wr) begin
        errors++;
        $display("FAIL mem_req_stable: got v=%0b a=0x%0h w=%0b want v=1 a=0x%0h w=%0b",
                 mem_req_valid, mem_req_addr, mem_req_write, prev_addr, prev_wr);
      end
    end
    if (mem_req_valid === 1'b1 && !prev_wait)
      stall_left = rand_mode ? int'($urandom_range(0, 3)) : stall_cfg;
    rdy = (mem_req_valid === 1'b1) && stall_left == 0;
    if (stall_left > 0) stall_left--;
    if (!busy && glitch && mem_req_valid === 1'b1 && mem_req_write && !rdy) mem_resp_valid = 1'b1;
    if (!busy && rand_mode && $urandom_range(0, 7) == 0) mem_resp_valid = 1'b1;
    if (mem_req_valid === 1'b1 && rdy) begin
      hs_count++;
      checks++;
      if (exp_mem.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem_req: got a=0x%0h w=%0b want no request",
                 mem_req_addr, mem_req_write);
      end else begin
        e = exp_mem.pop_front();
        if (mem_req_addr !== e.addr || mem_req_write !== e.wr) begin
          errors++;
          $display("FAIL mem_req: got a=0x%0h w=%0b want a=0x%0h w=%0b",
                   mem_req_addr, mem_req_write, e.addr, e.wr);
        end
      end
      busy = 1;
      lat_left = rand_mode ? int'($urandom_range(1, 4)) : lat_cfg;
    end
    mem_req_ready = rdy;
    prev_wait = (mem_req_valid === 1'b1) && !rdy;
    prev_addr = mem_req_addr;
    prev_wr   = mem_req_write;
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_resp_t e;
    if (!reset && resp_valid === 1'b1) begin
      checks++;
      if (exp_resp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got set=%0d way=%0d want no response", resp_set, resp_way);
      end else begin
        e = exp_resp.pop_front();
        if (resp_hit !== e.hit || resp_set !== e.set || resp_way !== e.way ||
            plru_load_mru !== 1'b1 || plru_mru_way !== e.way) begin
          errors++;
          $display("FAIL resp: got hit=%0b set=%0d way=%0d mru=%0b/%0d want hit=%0b set=%0d way=%0d mru=1/%0d",
                   resp_hit, resp_set, resp_way, plru_load_mru, plru_mru_way,
                   e.hit, e.set, e.way, e.way);
        end
        if (e.hit) begin
          checks++;
          if (cyc - e.acc != 2) begin
            errors++;
            $display("FAIL hit_latency: got %0d want 2", cyc - e.acc);
          end
        end
      end
    end else if (!reset && plru_load_mru === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL stray_mru: got plru_load_mru=1 want 0 without resp_valid");
    end
  end

  task automatic issue(input logic [31:0] a, input bit w, input int lru);
    int n = 0;
    int idx, vic;
    logic [23:0] tg;
    exp_resp_t e;
    while (req_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL req_ready_timeout: got 0 want 1 within 500 cycles");
        finish_up();
      end
    end
    idx = int'(a[7:4]);
    tg  = a[31:8];
    e.hit = 0;
    e.way = '0;
    for (int k = 0; k < 4; k++)
      if (!e.hit && m_val[idx][k] && m_tag[idx][k] == tg) begin
        e.hit = 1;
        e.way = 2'(k);
      end
    if (e.hit) begin
      if (w) m_dirty[idx][e.way] = 1;
    end else begin
      vic = lru;
      for (int k = 3; k >= 0; k--) if (!m_val[idx][k]) vic = k;
      if (m_val[idx][vic] && m_dirty[idx][vic])
        exp_mem.push_back('{{m_tag[idx][vic], 4'(idx), 4'h0}, 1'b1});
      exp_mem.push_back('{{tg, 4'(idx), 4'h0}, 1'b0});
      m_tag[idx][vic]   = tg;
      m_val[idx][vic]   = 1;
      m_dirty[idx][vic] = w;
      e.way = 2'(vic);
    end
    e.set = 4'(idx);
    e.acc = cyc;
    exp_resp.push_back(e);
    req_valid    = 1'b1;
    req_addr     = a;
    req_write    = w;
    plru_lru_way = 2'(lru);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    exp_resp.delete();
    exp_mem.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int h0, n;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_plru_load_mru", 32'(plru_load_mru), 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_misc", {resp_hit, resp_set, resp_way, mem_req_write, plru_set, plru_mru_way}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // cold miss then hit in the same line
    issue(32'h0000_1230, 0, 0);
    issue(32'h0000_1234, 0, 3);

    // fill set 3, then PLRU-selected eviction
    do_reset();
    for (int t = 1; t <= 4; t++) issue(32'(t << 8) | 32'h30, 0, 0);
    issue(32'h0000_0530, 0, 2);

    // dirty way 1, evict it under a stalled memory port with a spurious pulse
    issue(32'h0000_0234, 1, 0);
    stall_cfg = 5;
    glitch = 1;
    issue(32'h0000_0634, 0, 1);
    n = 0;
    while (exp_resp.size() != 0 && n < 200) begin @(negedge clk); n++; end
    stall_cfg = 0;
    glitch = 0;
    issue(32'h0000_0734, 0, 1);

    // reset while waiting for a fill
    lat_cfg = 30;
    issue(32'h0000_0830, 0, 0);
    h0 = hs_count;
    n = 0;
    while (hs_count == h0 && n < 100) begin @(negedge clk); n++; end
    chk("fill_handshake_seen", 32'(hs_count - h0), 32'd1);
    repeat (2) @(negedge clk);
    do_reset();
    chk("midop_req_ready", 32'(req_ready), 32'd1);
    chk("midop_resp_valid", 32'(resp_valid), 32'd0);
    chk("midop_mem_req_valid", 32'(mem_req_valid), 32'd0);
    lat_cfg = 3;
    issue(32'h0000_0830, 0, 0);

    // randomized traffic over a small footprint
    rand_mode = 1;
    for (int i = 0; i < 300; i++)
      issue((32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    n = 0;
    while (exp_resp.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_resp", 32'(exp_resp.size()), 32'd0);
    repeat (5) @(negedge clk);
    chk("drain_mem", 32'(exp_mem.size()), 32'd0);
    finish_up();
  end

endmodule
